// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  localparam int MD_LAT_DEF      = 32;
  localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction needs a register
// that the load currently in EX has not produced yet.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu_hazard
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu_hazard = ex_memread && (ex_rt != ZERO_REG) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use,
// taken branch, multi-cycle MUL/DIV and data-memory wait handling.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT      = MD_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             md_done,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MDC_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam int WC_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LAT - 1);
  localparam logic [WC_W-1:0]  WC_THR  = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0]  WC_MAX  = {WC_W{1'b1}};

  md_state_e        state, state_next;
  logic [MDC_W-1:0] md_cnt, md_cnt_next;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_next;
  logic             lu_hazard;
  logic             mem_wait;
  logic             md_stall;
  logic             md_release;
  logic raw_en_pc, raw_en_ifid, raw_en_idex, raw_en_exmem, raw_en_memwb;
  logic raw_flush_ifid, raw_flush_idex, raw_flush_exmem, raw_flush_memwb;

  load_use_detect u_lud (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .lu_hazard  (lu_hazard)
  );

  assign mem_wait = mem_req && !dmem_ready;

  // MUL/DIV occupancy FSM; the countdown runs through memory waits but the
  // release is held until the wait is over
  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    md_stall    = 1'b0;
    md_release  = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_wait && ex_md_start) begin
          md_stall    = 1'b1;
          md_cnt_next = MD_LOAD;
          state_next  = MD_BUSY;
        end else begin
          md_stall    = 1'b0;
        end
      end
      MD_BUSY: begin
        if (md_cnt != {MDC_W{1'b0}}) begin
          md_stall    = 1'b1;
          md_cnt_next = md_cnt - {{(MDC_W-1){1'b0}}, 1'b1};
        end else if (!mem_wait) begin
          md_release  = 1'b1;
          state_next  = IDLE;
        end else begin
          md_release  = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        md_cnt_next = {MDC_W{1'b0}};
      end
    endcase
  end

  // Priority resolution of enables and flushes
  always_comb begin
    raw_en_pc       = 1'b1;
    raw_en_ifid     = 1'b1;
    raw_en_idex     = 1'b1;
    raw_en_exmem    = 1'b1;
    raw_en_memwb    = 1'b1;
    raw_flush_ifid  = 1'b0;
    raw_flush_idex  = 1'b0;
    raw_flush_exmem = 1'b0;
    raw_flush_memwb = 1'b0;
    if (mem_wait) begin
      raw_en_pc       = 1'b0;
      raw_en_ifid     = 1'b0;
      raw_en_idex     = 1'b0;
      raw_en_exmem    = 1'b0;
      raw_flush_memwb = 1'b1;
    end else if (md_stall) begin
      raw_en_pc       = 1'b0;
      raw_en_ifid     = 1'b0;
      raw_en_idex     = 1'b0;
      raw_flush_exmem = 1'b1;
    end else if (ex_branch_taken) begin
      // the ID instruction is wrong-path, so any load-use stall is moot
      raw_flush_ifid  = 1'b1;
      raw_flush_idex  = 1'b1;
    end else if (lu_hazard) begin
      raw_en_pc       = 1'b0;
      raw_en_ifid     = 1'b0;
      raw_flush_idex  = 1'b1;
    end else begin
      raw_en_pc       = 1'b1;
    end
  end

  // Saturating count of consecutive wait cycles
  always_comb begin
    if (!mem_wait) begin
      wait_cnt_next = {WC_W{1'b0}};
    end else if (wait_cnt == WC_MAX) begin
      wait_cnt_next = wait_cnt;
    end else begin
      wait_cnt_next = wait_cnt + {{(WC_W-1){1'b0}}, 1'b1};
    end
  end

  assign en_pc       = rst && raw_en_pc;
  assign en_ifid     = rst && raw_en_ifid;
  assign en_idex     = rst && raw_en_idex;
  assign en_exmem    = rst && raw_en_exmem;
  assign en_memwb    = rst && raw_en_memwb;
  assign flush_ifid  = rst && raw_flush_ifid;
  assign flush_idex  = rst && raw_flush_idex;
  assign flush_exmem = rst && raw_flush_exmem;
  assign flush_memwb = rst && raw_flush_memwb;
  assign md_done     = rst && md_release;

  // State, counters and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      md_cnt    <= {MDC_W{1'b0}};
      wait_cnt  <= {WC_W{1'b0}};
      mem_err   <= 1'b0;
      stall_cnt <= {CNT_W{1'b0}};
    end else begin
      state    <= state_next;
      md_cnt   <= md_cnt_next;
      wait_cnt <= wait_cnt_next;
      if (mem_wait && (wait_cnt >= WC_THR)) begin
        mem_err <= 1'b1;
      end else begin
        mem_err <= mem_err;
      end
      if (!raw_en_pc) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MD_LAT = 4, MEM_TIMEOUT = 8).
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,flush_idex,flush_exmem,flush_memwb,md_done}
  localparam logic [9:0] E_RST  = 10'b00000_0000_0;
  localparam logic [9:0] E_DEF  = 10'b11111_0000_0;
  localparam logic [9:0] E_LU   = 10'b00111_0100_0;
  localparam logic [9:0] E_BR   = 10'b11111_1100_0;
  localparam logic [9:0] E_MD   = 10'b00011_0010_0;
  localparam logic [9:0] E_DONE = 10'b11111_0000_1;
  localparam logic [9:0] E_MW   = 10'b00001_0001_0;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, ex_branch_taken, ex_md_start;
  logic        mem_req, dmem_ready;
  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic        md_done, mem_err;
  logic [31:0] stall_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [9:0]  sb[$];
  logic [31:0] exp_stall = 32'd0;
  logic        exp_err   = 1'b0;

  pipe_hazard_ctrl #(.MD_LAT(4), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb), .md_done(md_done),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // A taken branch while MUL/DIV occupies EX is an illegal stimulus
  always @(posedge clk) begin
    if (rst && dut.state == MD_BUSY) begin
      assert (!ex_branch_taken) else begin
        bad++;
        $error("FAIL branch_in_md_busy observed=%b expected=0", ex_branch_taken);
      end
    end
  end

  // One cycle: queue expectation, check away from the edge, advance to next negedge
  task automatic cyc(input string tag, input logic [9:0] exp);
    logic [9:0] want, got;
    sb.push_back(exp);
    #2;
    if (!rst) begin
      exp_stall = 32'd0;
      exp_err   = 1'b0;
    end
    want = sb.pop_front();
    got  = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
            flush_ifid, flush_idex, flush_exmem, flush_memwb, md_done};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, got, want);
    end
    total++;
    assert (stall_cnt === exp_stall) else begin
      bad++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_stall);
    end
    total++;
    assert (mem_err === exp_err) else begin
      bad++;
      $error("FAIL %s mem_err observed=%b expected=%b", tag, mem_err, exp_err);
    end
    if (rst && !want[9]) exp_stall = exp_stall + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    cyc("reset", E_RST);
    rst = 1'b1;
    cyc("idle", E_DEF);

    // load-use on rs, then on rt, then masked variants
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    cyc("lu_rs", E_LU);
    ex_memread = 1'b0;
    cyc("lu_rs_after", E_DEF);
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
    cyc("lu_rt", E_LU);
    id_uses_rt = 1'b0;
    cyc("lu_rt_unused", E_DEF);
    ex_rt = 5'd0; id_rs = 5'd0;
    cyc("lu_r0", E_DEF);

    // branch overrides a simultaneous load-use
    ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
    cyc("br_lu", E_BR);
    ex_branch_taken = 1'b0; ex_memread = 1'b0;
    cyc("br_after", E_DEF);

    // MUL/DIV: exactly 4 stall cycles then md_done
    ex_md_start = 1'b1;
    for (int i = 0; i < 4; i++) cyc("md_stall", E_MD);
    cyc("md_done", E_DONE);
    ex_md_start = 1'b0;
    cyc("md_after", E_DEF);

    // memory wait holds a taken branch until the access completes
    mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mw_br", E_MW);
    dmem_ready = 1'b1;
    cyc("mw_br_release", E_BR);
    ex_branch_taken = 1'b0; mem_req = 1'b0;
    cyc("mw_after", E_DEF);

    // timeout: mem_err rises at the 8th consecutive wait cycle and sticks
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc("timeout_wait", E_MW);
    exp_err = 1'b1;
    dmem_ready = 1'b1;
    cyc("timeout_ready", E_DEF);
    mem_req = 1'b0;
    cyc("timeout_sticky", E_DEF);

    // MUL/DIV overlapped by a 6-cycle wait: md_done only after the wait
    ex_md_start = 1'b1;
    cyc("ovl_start", E_MD);
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc("ovl_wait", E_MW);
    mem_req = 1'b0;
    cyc("ovl_done", E_DONE);
    ex_md_start = 1'b0;
    cyc("ovl_after", E_DEF);

    // asynchronous reset in the middle of MD_BUSY
    ex_md_start = 1'b1;
    cyc("rst_md1", E_MD);
    cyc("rst_md2", E_MD);
    rst = 1'b0;
    cyc("rst_mid", E_RST);
    rst = 1'b1; ex_md_start = 1'b0;
    cyc("rst_release", E_DEF);
    cyc("rst_idle", E_DEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
